encoder_c74: RTL and testbench

//  Serial systematic (7,4) cyclic Hamming encoder; the transmit end of the decoder_A2 link.

---
 rtl/encoder_c74_if.sv | 26 ++
 rtl/encoder_c74.sv | 110 +++++++++++
 tb/tb_encoder_c74.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/encoder_c74_if.sv
// Serial link bundle for the (7,4) cyclic Hamming encoder: message input side,
// codeword output side and the transmitted-codeword counter.
interface encoder_c74_if #(
    parameter int CNT_W = 8
);
    logic             data_in;
    logic             in_valid;
    logic             in_flag;
    logic             inj_en;
    logic [2:0]       inj_pos;
    logic             out_ready;
    logic             data_out;
    logic             out_flag;
    logic [CNT_W-1:0] cw_count;

    // master drives the encoder (bench or upstream), slave is the encoder itself
    modport master (
        output data_in, in_valid, inj_en, inj_pos, out_ready,
        input  in_flag, data_out, out_flag, cw_count
    );

    modport slave (
        input  data_in, in_valid, inj_en, inj_pos, out_ready,
        output in_flag, data_out, out_flag, cw_count
    );
endinterface

// File: rtl/encoder_c74.sv
// Serial systematic (7,4) cyclic Hamming encoder: collects 4 message bits, then
// shifts out info bits followed by 3 LFSR parity bits, with optional single-bit flip.
module encoder_c74 #(
    parameter logic [2:0] GEN_POLY = 3'b011,
    parameter int         CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    encoder_c74_if.slave  bus
);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_SEND    = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_lfsr;
    logic [2:0]       r_msg;
    logic [1:0]       r_bit_cnt;
    logic [2:0]       r_out_cnt;
    logic [6:0]       r_cw_sr;
    logic [CNT_W-1:0] r_cw_count;

    logic       w_accept;
    logic       w_xfer;
    logic       w_last_in;
    logic       w_last_out;
    logic       w_fb;
    logic [2:0] w_lfsr_nxt;
    logic [6:0] w_inj_mask;

    assign w_accept   = bus.in_valid  && (r_state == S_COLLECT);
    assign w_xfer     = bus.out_ready && (r_state == S_SEND);
    assign w_last_in  = w_accept && (r_bit_cnt == 2'd3);
    assign w_last_out = w_xfer   && (r_out_cnt == 3'd6);

    // Premultiplied form: message bit enters at the top, so the register holds m(x)*x^3 mod g(x)
    assign w_fb       = bus.data_in ^ r_lfsr[2];
    assign w_lfsr_nxt = {r_lfsr[1] ^ (w_fb & GEN_POLY[2]),
                         r_lfsr[0] ^ (w_fb & GEN_POLY[1]),
                         w_fb};

    assign w_inj_mask = (bus.inj_en && (bus.inj_pos != 3'd7)) ? (7'b1000000 >> bus.inj_pos)
                                                              : 7'b0000000;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
            // order of statements in sequential blocks never changes the result.
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: if (w_last_in)  w_next_state = S_SEND;
            S_SEND:    if (w_last_out) w_next_state = S_COLLECT;
            default:   w_next_state = S_COLLECT;
        endcase
    end

    // Output logic: data_out is forced low whenever no codeword bit is on offer
    always_comb begin
        bus.in_flag  = (r_state == S_COLLECT);
        bus.out_flag = (r_state == S_SEND);
        bus.data_out = (r_state == S_SEND) && r_cw_sr[6];
        bus.cw_count = r_cw_count;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr     <= 3'd0;
            r_msg      <= 3'd0;
            r_bit_cnt  <= 2'd0;
            r_out_cnt  <= 3'd0;
            r_cw_sr    <= 7'd0;
            r_cw_count <= '0;
        end else begin
            if (w_last_in) begin
                r_cw_sr   <= {r_msg, bus.data_in, w_lfsr_nxt} ^ w_inj_mask;
                r_lfsr    <= 3'd0;
                r_msg     <= 3'd0;
                r_bit_cnt <= 2'd0;
            end else if (w_accept) begin
                r_lfsr    <= w_lfsr_nxt;
                r_msg     <= {r_msg[1:0], bus.data_in};
                r_bit_cnt <= r_bit_cnt + 2'd1;
            end

            if (w_last_out) begin
                r_cw_sr    <= 7'd0;
                r_out_cnt  <= 3'd0;
                r_cw_count <= r_cw_count + 1'b1;
            end else if (w_xfer) begin
                r_cw_sr   <= {r_cw_sr[5:0], 1'b0};
                r_out_cnt <= r_out_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_encoder_c74.sv
// Directed bench for encoder_c74: vector table of messages/injections plus
// stall, reset-abort, exhaustive injection and counter-wrap sequences.
module tb_encoder_c74;

    logic clk;
    logic rst;

    encoder_c74_if #(.CNT_W(8)) bus ();

    encoder_c74 #(.GEN_POLY(3'b011), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_count = 8'd0;

    typedef struct {
        logic [3:0] msg;
        logic       inj_en;
        logic [2:0] inj_pos;
        logic [6:0] exp_cw;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference codeword by polynomial long division of m(x)*x^3 by g(x)=x^3+x+1
    function automatic logic [6:0] ref_cw(input logic [3:0] m, input logic [2:0] ip);
        logic [6:0] r;
        logic [6:0] g;
        logic [6:0] flip;
        r = {m, 3'b000};
        g = 7'b0001011;
        for (int i = 6; i >= 3; i--) begin
            if (r[i]) r = r ^ (g << (i - 3));
        end
        flip = (ip < 3'd7) ? (7'b1000000 >> ip) : 7'b0000000;
        return {m, r[2:0]} ^ flip;
    endfunction

    task automatic send_msg(input logic [3:0] m, input logic ie, input logic [2:0] ip,
                            input int nbits);
        int waited;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            waited = 0;
            while (!bus.in_flag && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 50) check("in_flag wait timeout", 0, 1);
            bus.data_in  = m[3-i];
            bus.in_valid = 1'b1;
            bus.inj_en   = ie;
            bus.inj_pos  = ip;
        end
    endtask

    // Receives nbits codeword bits; nbits==7 runs the end-of-word checks too
    task automatic recv_word(input logic [6:0] exp, input string name, input bit stall,
                             input bit pulse, input int nbits);
        logic [6:0] got;
        int         k;
        int         cyc;
        int         low;
        bit         rdy;
        bit         prev_stall;
        logic       prev_d;
        got = 7'd0; k = 0; cyc = 0; low = 0; prev_stall = 0; prev_d = 1'b0;
        @(negedge clk);
        bus.in_valid = pulse;
        bus.data_in  = pulse;
        bus.inj_en   = pulse;
        bus.inj_pos  = 3'd0;
        check({name, " latency"}, bus.out_flag, 1'b1);
        while (k < nbits && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            bus.out_ready = rdy;
            if (!bus.in_flag) low++;
            if (prev_stall) begin
                check({name, " stall hold data"}, bus.data_out, prev_d);
                check({name, " stall hold flag"}, bus.out_flag, 1'b1);
            end
            if (bus.out_flag && rdy) begin
                got = {got[5:0], bus.data_out};
                k++;
            end
            prev_stall = !rdy && bus.out_flag;
            prev_d     = bus.data_out;
            cyc++;
        end
        if (cyc >= 200) check({name, " send timeout"}, 0, 1);
        if (nbits == 7) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.inj_en    = 1'b0;
            bus.out_ready = 1'b1;
            exp_count     = exp_count + 8'd1;
            check({name, " word"}, got, exp);
            check({name, " out_flag end"}, bus.out_flag, 1'b0);
            check({name, " data_out end"}, bus.data_out, 1'b0);
            check({name, " in_flag end"}, bus.in_flag, 1'b1);
            check({name, " cw_count"}, bus.cw_count, exp_count);
            if (!stall) check({name, " in_flag low cycles"}, low, 7);
        end else begin
            bus.in_valid = 1'b0;
            bus.inj_en   = 1'b0;
            check({name, " partial word"}, got, exp >> (7 - nbits));
        end
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check({name, " in_flag"}, bus.in_flag, 1'b1);
        check({name, " out_flag"}, bus.out_flag, 1'b0);
        check({name, " data_out"}, bus.data_out, 1'b0);
        check({name, " cw_count"}, bus.cw_count, 8'd0);
        rst = 1'b0;
        exp_count = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check({name, " no emit after reset"}, bus.out_flag, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{4'b1000, 1'b0, 3'd7, 7'b1000101};
        vecs[1] = '{4'b0001, 1'b0, 3'd7, 7'b0001011};
        vecs[2] = '{4'b1111, 1'b0, 3'd7, 7'b1111111};
        vecs[3] = '{4'b0000, 1'b0, 3'd7, 7'b0000000};
        vecs[4] = '{4'b1000, 1'b1, 3'd0, 7'b0000101};
        vecs[5] = '{4'b1000, 1'b1, 3'd6, 7'b1000100};
        vecs[6] = '{4'b1000, 1'b1, 3'd7, 7'b1000101};
        vecs[7] = '{4'b1000, 1'b0, 3'd3, 7'b1000101};
        vecs[8] = '{4'b0110, 1'b0, 3'd7, 7'b0110001};
        vecs[9] = '{4'b0110, 1'b1, 3'd3, 7'b0111001};

        rst = 1'b1;
        bus.data_in = 1'b0; bus.in_valid = 1'b0; bus.inj_en = 1'b0;
        bus.inj_pos = 3'd7; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_flag", bus.in_flag, 1'b1);
        check("reset out_flag", bus.out_flag, 1'b0);
        check("reset data_out", bus.data_out, 1'b0);
        check("reset cw_count", bus.cw_count, 8'd0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            send_msg(vecs[v].msg, vecs[v].inj_en, vecs[v].inj_pos, 4);
            recv_word(vecs[v].exp_cw, $sformatf("vec%0d", v), 1'b0, 1'b0, 7);
        end

        // Stalled output with in_valid pulses during send; 1011 is a multiple of g(x)
        send_msg(4'b1011, 1'b0, 3'd7, 4);
        recv_word(7'b1011000, "stall", 1'b1, 1'b1, 7);
        send_msg(4'b0001, 1'b0, 3'd7, 4);
        recv_word(7'b0001011, "after stall", 1'b0, 1'b0, 7);

        // Reset mid-collect, then mid-send
        send_msg(4'b1111, 1'b0, 3'd7, 2);
        pulse_reset("rst collect");
        send_msg(4'b1000, 1'b0, 3'd7, 4);
        recv_word(7'b1000101, "post rst collect", 1'b0, 1'b0, 7);
        send_msg(4'b1111, 1'b0, 3'd7, 4);
        recv_word(7'b1111111, "pre rst send", 1'b0, 1'b0, 3);
        pulse_reset("rst send");
        send_msg(4'b0001, 1'b0, 3'd7, 4);
        recv_word(7'b0001011, "post rst send", 1'b0, 1'b0, 7);

        // Every message with every injection position
        for (int m = 0; m < 16; m++) begin
            for (int p = 0; p < 8; p++) begin
                send_msg(4'(m), 1'b1, 3'(p), 4);
                recv_word(ref_cw(4'(m), 3'(p)), $sformatf("loop m%0d p%0d", m, p),
                          1'b0, 1'b0, 7);
            end
        end

        // Run past 256 words since the last reset so cw_count wraps
        for (int w = 0; w < 130; w++) begin
            logic [3:0] m;
            m = 4'($urandom_range(0, 15));
            send_msg(m, 1'b0, 3'd7, 4);
            recv_word(ref_cw(m, 3'd7), $sformatf("wrap w%0d", w), 1'b0, 1'b0, 7);
        end
        check("cw_count wrapped", bus.cw_count, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
